// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : PC sequencer and fetch FIFO for the 16-bit CPU's instruction memory
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
  parameter logic [15:0] START_PC = 16'd10,
  parameter logic [3:0]  HALT_OP  = 4'hF,
  parameter int          DEPTH    = 2,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic        halted
);

  localparam int                c_cw       = $clog2(DEPTH + 1);
  localparam int                c_pw       = $clog2(DEPTH);
  localparam logic [c_cw-1:0]   c_depth    = c_cw'(DEPTH);
  localparam logic [c_pw-1:0]   c_last_ptr = c_pw'(DEPTH - 1);
  localparam logic [15:0]       c_pc_mask  = 16'hFFFE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_pc, w_pc_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic [c_pw-1:0]   r_head, r_tail, w_rd_idx;
  logic [c_cw-1:0]   r_count;
  logic              w_push, w_pop, w_flush;

  assign w_pop   = instr_valid & instr_ready;
  assign w_flush = redirect & (r_state != ST_IDLE);
  assign w_push  = (r_state == ST_RUN) & ~redirect & ((r_count < c_depth) | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = START_PC & c_pc_mask;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc & c_pc_mask;
        end else if (w_push) begin
          w_pc_nxt = r_pc + PC_STEP;
          if (imem_data[15:12] == HALT_OP) begin
            w_state_nxt = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        if (redirect) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = redirect_pc & c_pc_mask;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = 16'h0000;
      end
    endcase
  end

  // A flush rewinds the tail onto the head so the last-delivered slot still sits just behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else if (w_flush) begin
      r_tail  <= r_head;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= {r_pc, imem_data};
        r_tail        <= (r_tail == c_last_ptr) ? '0 : r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= (r_head == c_last_ptr) ? '0 : r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When empty, show the slot just behind the head so the outputs hold their last value.
  always_comb begin
    w_rd_idx = r_head;
    if (r_count == '0) begin
      w_rd_idx = (r_head == '0) ? c_last_ptr : r_head - 1'b1;
    end
  end

  assign {instr_pc, instr} = r_mem[w_rd_idx];
  assign instr_valid       = (r_count != '0);
  assign imem_addr         = r_pc;
  assign busy              = (r_state == ST_RUN);
  assign halted            = (r_state == ST_HALTED) & (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Directed self-checking bench for fetch_controller
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        halted;

  logic        halt_en;
  logic [15:0] halt_addr;
  int          checks;
  int          errors;

  fetch_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .busy       (busy),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memword(input logic [15:0] a);
    return {4'h1, a[11:0]};
  endfunction

  always_comb begin
    imem_data = memword(imem_addr);
    if (halt_en && (imem_addr == halt_addr)) imem_data = 16'hF0AA;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    start       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = 1'b0;
    halt_en     = 1'b0;
    halt_addr   = 16'h0000;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    #2;
    check("rst_valid", instr_valid, 0);
    check("rst_busy",  busy,        0);
    check("rst_halt",  halted,      0);
    check("rst_addr",  imem_addr,   0);
    check("rst_instr", instr,       0);
    check("rst_ipc",   instr_pc,    0);

    // Streaming fetch with decode always ready
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    check("t2_busy",  busy,        1);
    check("t2_addr",  imem_addr,   16'd10);
    check("t2_empty", instr_valid, 0);
    start       = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_valid", instr_valid, 1);
      check("t2_pc",    instr_pc,    16'd10 + 16'(2 * i));
      check("t2_instr", instr,       memword(16'd10 + 16'(2 * i)));
    end

    // Back-pressure fills the FIFO, then drains without gaps
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    start       = 1'b1;
    instr_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("t3_full_pc",   instr_pc,  16'd10);
    check("t3_full_addr", imem_addr, 16'd14);
    tick();
    check("t3_hold_addr", imem_addr, 16'd14);
    check("t3_hold_pc",   instr_pc,  16'd10);
    instr_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t3_drain_v",  instr_valid, 1);
      check("t3_drain_pc", instr_pc,    16'd10 + 16'(2 * i));
    end

    // Redirect flushes two queued entries
    check("t4_pre_valid", instr_valid, 1);
    redirect    = 1'b1;
    redirect_pc = 16'h0031;
    tick();
    check("t4_flush_v", instr_valid, 0);
    check("t4_addr",    imem_addr,   16'h0030);
    check("t4_busy",    busy,        1);
    redirect = 1'b0;
    tick();
    check("t4_v",   instr_valid, 1);
    check("t4_pc0", instr_pc,    16'h0030);
    tick();
    check("t4_pc1", instr_pc,    16'h0032);

    // Asynchronous reset mid-run with a full FIFO
    instr_ready = 1'b0;
    tick();
    tick();
    tick();
    check("t1_pre_valid", instr_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t1_valid", instr_valid, 0);
    check("t1_busy",  busy,        0);
    check("t1_addr",  imem_addr,   0);
    check("t1_ipc",   instr_pc,    0);

    // Halt opcode at pc 16, then restart by redirect
    @(negedge clk);
    rst_n       = 1'b1;
    halt_en     = 1'b1;
    halt_addr   = 16'd16;
    start       = 1'b1;
    instr_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_pc", instr_pc, 16'd10 + 16'(2 * i));
    end
    check("t5_hinstr",    instr,  16'hF0AA);
    check("t5_busy_off",  busy,   0);
    check("t5_not_yet",   halted, 0);
    tick();
    check("t5_drained_v", instr_valid, 0);
    check("t5_halted",    halted,      1);
    check("t5_hold_pc",   instr_pc,    16'd16);
    tick();
    check("t5_no_fetch",  instr_valid, 0);
    check("t5_still_h",   halted,      1);
    redirect    = 1'b1;
    redirect_pc = 16'd40;
    tick();
    check("t5_rbusy", busy,        1);
    check("t5_rhalt", halted,      0);
    check("t5_rv",    instr_valid, 0);
    redirect = 1'b0;
    tick();
    check("t5_pc40", instr_pc, 16'd40);
    tick();
    check("t5_pc42", instr_pc, 16'd42);

    // PC wraps from 16'hFFFE to 16'h0000
    halt_en     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    tick();
    check("t6_pc_top",  instr_pc, 16'hFFFE);
    check("t6_in_top",  instr,    memword(16'hFFFE));
    tick();
    check("t6_pc_wrap", instr_pc, 16'h0000);
    check("t6_in_wrap", instr,    16'h1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
